cla_adder_pipe: RTL

//   Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.

---
 rtl/cla_adder_pipe.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: parametrised, pipelined carry-lookahead adder/subtractor.
// Stage k adds segment k (WIDTH/STAGES bits, LSB segment first) using a
// two-level lookahead: bit-level inside GROUP-bit groups, group-level across
// the segment. Upper operand segments travel forward in skew registers and
// finished lower result segments in deskew registers, so a beat's full result
// emerges at once after STAGES cycles. A single global advance signal
// (output slot empty or being consumed) stalls every stage together.
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG_W = WIDTH / STAGES;
    localparam int NGRP  = SEG_W / GROUP;
    // One lookahead function serves both the bit level and the group level
    localparam int LA_W  = (GROUP > NGRP) ? GROUP : NGRP;
    // Inter-stage banks; the last stage feeds the output registers instead
    localparam int NBANK = (STAGES > 1) ? STAGES - 1 : 1;

    // Refuse to build a geometry that cannot be split into whole groups per stage
    if (STAGES < 1 || GROUP < 1 || WIDTH < 1 || (WIDTH % (GROUP * STAGES)) != 0) begin : g_bad_params
        $fatal(1, "cla_adder_pipe: WIDTH must be a positive multiple of GROUP*STAGES");
    end

    // Carries c[0..n] of an n-bit block in sum-of-products lookahead form:
    // c[i] = ci&p[0..i-1] | OR over m<i of g[m]&p[m+1..i-1]
    function automatic logic [LA_W:0] lookahead(
        input logic [LA_W-1:0] g,
        input logic [LA_W-1:0] p,
        input logic            ci,
        input int              n
    );
        logic [LA_W:0] c;
        logic          term;
        c = '0;
        for (int i = 0; i <= LA_W; i++) begin
            if (i <= n) begin
                term = ci;
                for (int l = 0; l < LA_W; l++) begin
                    if (l < i) term = term & p[l];
                end
                c[i] = term;
                for (int m = 0; m < LA_W; m++) begin
                    if (m < i) begin
                        term = g[m];
                        for (int l = 0; l < LA_W; l++) begin
                            if (l > m && l < i) term = term & p[l];
                        end
                        c[i] = c[i] | term;
                    end
                end
            end
        end
        return c;
    endfunction

    // One segment add: returns {carry into segment MSB, segment carry-out, segment sum}
    function automatic logic [SEG_W+1:0] seg_add(
        input logic [SEG_W-1:0] sa,
        input logic [SEG_W-1:0] sb,
        input logic             ci
    );
        logic [SEG_W-1:0] p;
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] s;
        logic [LA_W-1:0]  gx;
        logic [LA_W-1:0]  px;
        logic [LA_W-1:0]  gg;
        logic [LA_W-1:0]  gp;
        logic [LA_W:0]    la;
        logic [LA_W:0]    gc;
        logic             cmsb;
        p    = sa ^ sb;
        g    = sa & sb;
        gg   = '0;
        gp   = '0;
        s    = '0;
        cmsb = 1'b0;
        // group generate / propagate
        for (int j = 0; j < NGRP; j++) begin
            gx = '0;
            px = '0;
            gx[GROUP-1:0] = g[j*GROUP +: GROUP];
            px[GROUP-1:0] = p[j*GROUP +: GROUP];
            la    = lookahead(gx, px, 1'b0, GROUP);
            gg[j] = la[GROUP];
            gp[j] = &p[j*GROUP +: GROUP];
        end
        // carries into each group, straight from the segment carry-in
        gc = lookahead(gg, gp, ci, NGRP);
        // bit carries inside each group start from that group's carry
        for (int j = 0; j < NGRP; j++) begin
            gx = '0;
            px = '0;
            gx[GROUP-1:0] = g[j*GROUP +: GROUP];
            px[GROUP-1:0] = p[j*GROUP +: GROUP];
            la = lookahead(gx, px, gc[j], GROUP);
            for (int i = 0; i < GROUP; i++) begin
                s[j*GROUP + i] = px[i] ^ la[i];
            end
            // the last group's value is the carry into the segment MSB
            cmsb = la[GROUP-1];
        end
        return {cmsb, gc[NGRP], s};
    endfunction

    // Overlay a finished segment onto the partial result carried with the beat
    function automatic logic [WIDTH-1:0] insert_seg(
        input logic [WIDTH-1:0] full,
        input logic [SEG_W-1:0] seg,
        input int               k
    );
        logic [WIDTH-1:0] r;
        r = full;
        r[k*SEG_W +: SEG_W] = seg;
        return r;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Per-stage inputs and combinational results
    logic [WIDTH-1:0] a_s    [STAGES];
    logic [WIDTH-1:0] b_s    [STAGES];
    logic [WIDTH-1:0] acc_s  [STAGES];
    logic             ci_s   [STAGES];
    logic             v_s    [STAGES];
    logic [SEG_W+1:0] res_s  [STAGES];
    logic [WIDTH-1:0] part_s [STAGES];

    // Pipeline state
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  a_q    [NBANK];
    logic [WIDTH-1:0]  b_q    [NBANK];
    logic [WIDTH-1:0]  part_q [NBANK];
    logic              cy_q   [NBANK];
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic [WIDTH-1:0]  sum_d;
    logic              cout_d;
    logic              ovf_d;

    // Subtraction is a + ~b + ~cin; the borrow-in is inverted like b
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    // Whole pipe moves together: bubbles advance too, nothing collapses
    assign out_valid = vld_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_s[k]   = a;
            assign b_s[k]   = b_eff;
            assign ci_s[k]  = c0;
            assign v_s[k]   = in_valid;
            assign acc_s[k] = '0;
        end else begin : g_next
            assign a_s[k]   = a_q[k-1];
            assign b_s[k]   = b_q[k-1];
            assign ci_s[k]  = cy_q[k-1];
            assign v_s[k]   = vld_q[k-1];
            assign acc_s[k] = part_q[k-1];
        end
        assign res_s[k]  = seg_add(a_s[k][k*SEG_W +: SEG_W], b_s[k][k*SEG_W +: SEG_W], ci_s[k]);
        assign part_s[k] = insert_seg(acc_s[k], res_s[k][SEG_W-1:0], k);
    end

    // Final stage: full result plus flags; ovf = carry into MSB ^ carry out of MSB
    assign sum_d  = part_s[STAGES-1];
    assign cout_d = res_s[STAGES-1][SEG_W];
    assign ovf_d  = res_s[STAGES-1][SEG_W+1] ^ res_s[STAGES-1][SEG_W];

    // Stage valid bits: cleared by reset so in-flight beats are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= v_s[k];
            end
        end
    end

    // Skew (upper operands) and deskew (lower sums) banks, loaded only for valid beats
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES - 1; k++) begin
            if (advance && v_s[k]) begin
                a_q[k]    <= a_s[k];
                b_q[k]    <= b_s[k];
                part_q[k] <= part_s[k];
                cy_q[k]   <= res_s[k][SEG_W];
            end
        end
    end

    // Output registers: cleared on reset, updated only when a valid beat lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance && v_s[STAGES-1]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
